// File: rtl/sprite_cmd_dispatcher.sv
// sprite_cmd_dispatcher
//
// Purpose:
//   Buffers CPU command words from an Avalon-MM slave write port in a FIFO and
//   broadcasts one word per cycle on the shared sprite command bus. Buffer-swap
//   commands (action field [20:17] == 4'hF) are held at the FIFO head until the
//   first pixel of vertical blank. This means ping/pong buffer toggles never land
//   mid-frame. When there is nothing to issue, the bus carries NOP_WORD.
//
// Optional feature macro: DISPATCH_STATS_EN
//   When this macro is defined, saturating issued/drop statistics counters are built.
//   When it is undefined, issued_count and drop_count are tied to zero.
//
// Ports:
//   clk           in   1   system clock
//   reset         in   1   asynchronous active-low reset
//   chipselect    in   1   Avalon slave select
//   write         in   1   Avalon write strobe
//   writedata     in  32   command word: [31:26] component, [20:17] action,
//                          [16:14] type, [13] toggle, [12:0] data
//   hcount        in  10   current horizontal count
//   vcount        in  10   current vertical count
//   cmd_out       out 32   registered broadcast word
//   fifo_full     out  1   FIFO holds FIFO_DEPTH words
//   fifo_empty    out  1   FIFO holds no words
//   overflow      out  1   sticky, set by a rejected write
//   swap_pending  out  1   a swap is waiting for vertical blank
//   active_buffer out  1   toggle bit of the last issued swap
//   issued_count  out 16   non-NOP words issued (statistics)
//   drop_count    out 16   rejected writes (statistics)
//   state_dbg     out  1   FSM state (0 = IDLE, 1 = WAIT_SYNC)

module sprite_cmd_dispatcher #(
    parameter int          FIFO_DEPTH  = 16,
    parameter int          ADDR_W      = 4,
    parameter logic [9:0]  VBLANK_LINE = 10'd480,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic [31:0] cmd_out,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic        overflow,
    output logic        swap_pending,
    output logic        active_buffer,
    output logic [15:0] issued_count,
    output logic [15:0] drop_count,
    output logic        state_dbg
);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_SYNC = 1'b1
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(FIFO_DEPTH);

    state_t            state, next_state;
    logic [31:0]       mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic [31:0]       head;
    logic              head_is_swap;
    logic              vblank_start;
    logic              accept, reject, pop, take_swap;
    logic [31:0]       next_cmd;

    // Write handshake: a word transfers at a rising edge where
    // chipselect && write (valid) and !fifo_full (ready). If valid is high
    // while ready is low, the word is dropped and overflow is set. The CPU
    // side has no backpressure. fifo_full comes from the registered count.
    // As a result, a write into a full FIFO is dropped even when a pop
    // happens at the same edge.
    assign fifo_full  = (count == DEPTH_CNT);
    assign fifo_empty = (count == '0);
    assign accept     = chipselect && write && !fifo_full;
    assign reject     = chipselect && write && fifo_full;

    assign head         = mem[rd_ptr];
    assign head_is_swap = (head[20:17] == 4'hF);
    assign vblank_start = (vcount == VBLANK_LINE) && (hcount == 10'd0);

    assign swap_pending = (state == WAIT_SYNC);
    assign state_dbg    = state;

    // Next-state and issue decode. In IDLE, a swap at the head is tested
    // against vblank_start in the same cycle. So a swap that arrives exactly
    // at vblank_start issues at once, without passing through WAIT_SYNC.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        take_swap  = 1'b0;
        next_cmd   = NOP_WORD;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    if (!head_is_swap) begin
                        pop      = 1'b1;
                        next_cmd = head;
                    end else if (vblank_start) begin
                        pop       = 1'b1;
                        take_swap = 1'b1;
                        next_cmd  = head;
                    end else begin
                        next_state = WAIT_SYNC;
                    end
                end
            end
            WAIT_SYNC: begin
                if (vblank_start && !fifo_empty) begin
                    pop        = 1'b1;
                    take_swap  = 1'b1;
                    next_cmd   = head;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cmd_out       <= NOP_WORD;
            overflow      <= 1'b0;
            active_buffer <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
        end else begin
            state   <= next_state;
            cmd_out <= next_cmd;
            if (reject)
                overflow <= 1'b1;
            if (take_swap)
                active_buffer <= head[13];
            if (accept)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({accept, pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset. Clearing the pointers on reset discards the contents.
    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= writedata;
    end

`ifdef DISPATCH_STATS_EN
    logic [15:0] issued_q, drop_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issued_q <= 16'h0;
            drop_q   <= 16'h0;
        end else begin
            if (pop && (next_cmd != NOP_WORD) && (issued_q != 16'hFFFF))
                issued_q <= issued_q + 16'd1;
            if (reject && (drop_q != 16'hFFFF))
                drop_q <= drop_q + 16'd1;
        end
    end

    assign issued_count = issued_q;
    assign drop_count   = drop_q;
`else
    assign issued_count = 16'h0;
    assign drop_count   = 16'h0;
`endif

endmodule

// File: tb/tb_sprite_cmd_dispatcher.sv
// tb_sprite_cmd_dispatcher
//
// Purpose: a directed bench for sprite_cmd_dispatcher. It drives the inputs
// just after the rising edge and samples the outputs on the falling edge.
// The raster position is driven directly, which places vblank_start
// precisely.
// Optional feature macro: DISPATCH_STATS_EN. When it is defined, the bench
// expects live statistics counters.
// Ports: none (top-level bench).

module tb_sprite_cmd_dispatcher;

    logic        clk;
    logic        reset;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [31:0] cmd_out;
    logic        fifo_full;
    logic        fifo_empty;
    logic        overflow;
    logic        swap_pending;
    logic        active_buffer;
    logic [15:0] issued_count;
    logic [15:0] drop_count;
    logic        state_dbg;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] SINGLE_W = 32'h2402_800A;
    localparam logic [31:0] SWAP_T1  = 32'h001E_2000;
    localparam logic [31:0] SWAP_T0  = 32'h001E_0000;
    localparam logic [31:0] POS_W    = 32'h2402_8014;

`ifdef DISPATCH_STATS_EN
    localparam logic [15:0] EXP_ISSUED = 16'd6;
    localparam logic [15:0] EXP_DROP   = 16'd1;
`else
    localparam logic [15:0] EXP_ISSUED = 16'd0;
    localparam logic [15:0] EXP_DROP   = 16'd0;
`endif

    sprite_cmd_dispatcher dut (
        .clk           (clk),
        .reset         (reset),
        .chipselect    (chipselect),
        .write         (write),
        .writedata     (writedata),
        .hcount        (hcount),
        .vcount        (vcount),
        .cmd_out       (cmd_out),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .overflow      (overflow),
        .swap_pending  (swap_pending),
        .active_buffer (active_buffer),
        .issued_count  (issued_count),
        .drop_count    (drop_count),
        .state_dbg     (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Check helper
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Driver: one accepted-or-dropped write cycle
    task automatic write_word(input logic [31:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        chipselect = 1'b1;
        write      = 1'b1;
        writedata  = 32'hDEAD_BEEF;
        hcount     = 10'd5;
        vcount     = 10'd100;

        // Reset is held with writes active.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd",     cmd_out,       32'h0);
        chk("rst_empty",   {31'h0, fifo_empty}, 32'h1);
        chk("rst_full",    {31'h0, fifo_full},  32'h0);
        chk("rst_ovf",     {31'h0, overflow},   32'h0);
        chk("rst_active",  {31'h0, active_buffer}, 32'h0);
        @(posedge clk);
        #1;
        reset      = 1'b1;
        chipselect = 1'b0;
        write      = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd",   cmd_out, 32'h0);
        chk("post_rst_empty", {31'h0, fifo_empty}, 32'h1);

        // Single command: visible only in the cycle after E1.
        write_word(SINGLE_W);
        @(negedge clk);
        chk("single_e0_no_bypass", cmd_out, 32'h0);
        chk("single_e0_not_empty", {31'h0, fifo_empty}, 32'h0);
        @(negedge clk);
        chk("single_e1", cmd_out, SINGLE_W);
        @(negedge clk);
        chk("single_e2_nop", cmd_out, 32'h0);
        chk("single_e2_empty", {31'h0, fifo_empty}, 32'h1);

        // Burst of three words on consecutive cycles.
        chipselect = 1'b1;
        write      = 1'b1;
        writedata  = 32'h0402_0001;
        @(posedge clk);
        #1;
        writedata  = 32'h0802_0002;
        @(negedge clk);
        chk("burst_e0", cmd_out, 32'h0);
        @(posedge clk);
        #1;
        writedata  = 32'h0C02_0003;
        @(negedge clk);
        chk("burst_w0", cmd_out, 32'h0402_0001);
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write      = 1'b0;
        @(negedge clk);
        chk("burst_w1", cmd_out, 32'h0802_0002);
        @(negedge clk);
        chk("burst_w2", cmd_out, 32'h0C02_0003);
        @(negedge clk);
        chk("burst_end_nop", cmd_out, 32'h0);
        chk("burst_end_empty", {31'h0, fifo_empty}, 32'h1);

        // Swap hold until vblank_start, followed by a position word.
        write_word(SWAP_T1);
        write_word(POS_W);
        @(negedge clk);
        chk("swap_pending_set", {31'h0, swap_pending}, 32'h1);
        chk("swap_state_dbg",   {31'h0, state_dbg},    32'h1);
        chk("swap_hold_nop",    cmd_out, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("swap_hold_loop", cmd_out, 32'h0);
        end
        @(posedge clk);
        #1;
        vcount = 10'd480;
        hcount = 10'd1;
        @(posedge clk);
        #1;
        hcount = 10'd0;
        @(negedge clk);
        chk("swap_hcount1_hold", {31'h0, swap_pending}, 32'h1);
        chk("swap_hcount1_nop",  cmd_out, 32'h0);
        @(posedge clk);
        #1;
        hcount = 10'd1;
        @(negedge clk);
        chk("swap_issue",        cmd_out, SWAP_T1);
        chk("swap_active",       {31'h0, active_buffer}, 32'h1);
        chk("swap_pending_clr",  {31'h0, swap_pending}, 32'h0);
        @(negedge clk);
        chk("swap_then_pos", cmd_out, POS_W);
        @(negedge clk);
        chk("swap_after_nop", cmd_out, 32'h0);
        vcount = 10'd100;
        hcount = 10'd5;
        chk("issued_count", {16'h0, issued_count}, {16'h0, EXP_ISSUED});

        // Overflow: a swap plus 15 words fill the FIFO, and the 17th write is dropped.
        chipselect = 1'b1;
        write      = 1'b1;
        for (int i = 0; i < 16; i++) begin
            writedata = (i == 0) ? SWAP_T0 : (32'h2400_0000 | 32'(i));
            @(posedge clk);
            #1;
        end
        writedata = 32'h2400_00FF;
        @(negedge clk);
        chk("ovf_full16",    {31'h0, fifo_full},    32'h1);
        chk("ovf_not_yet",   {31'h0, overflow},     32'h0);
        chk("ovf_pending",   {31'h0, swap_pending}, 32'h1);
        chk("ovf_hold_nop",  cmd_out, 32'h0);
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write      = 1'b0;
        @(negedge clk);
        chk("ovf_sticky",    {31'h0, overflow},  32'h1);
        chk("ovf_still_full", {31'h0, fifo_full}, 32'h1);
        chk("drop_count",    {16'h0, drop_count}, {16'h0, EXP_DROP});

        // Reset is asserted while the swap waits.
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_pending", {31'h0, swap_pending},  32'h0);
        chk("midrst_empty",   {31'h0, fifo_empty},    32'h1);
        chk("midrst_full",    {31'h0, fifo_full},     32'h0);
        chk("midrst_ovf",     {31'h0, overflow},      32'h0);
        chk("midrst_active",  {31'h0, active_buffer}, 32'h0);
        chk("midrst_drop",    {16'h0, drop_count},    32'h0);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        vcount = 10'd480;
        hcount = 10'd0;
        @(posedge clk);
        #1;
        hcount = 10'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_issue", cmd_out, 32'h0);
        end
        chk("midrst_no_issue_cnt", {16'h0, issued_count}, 32'h0);

        // A swap that arrives exactly at vblank_start issues immediately.
        vcount = 10'd480;
        hcount = 10'd0;
        write_word(SWAP_T1);
        @(negedge clk);
        chk("imm_e0_nop",     cmd_out, 32'h0);
        @(negedge clk);
        chk("imm_issue",      cmd_out, SWAP_T1);
        chk("imm_active",     {31'h0, active_buffer}, 32'h1);
        chk("imm_no_pending", {31'h0, swap_pending},  32'h0);
        hcount = 10'd5;
        vcount = 10'd100;
        @(negedge clk);
        chk("imm_after_nop",   cmd_out, 32'h0);
        chk("imm_after_empty", {31'h0, fifo_empty}, 32'h1);

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_cmd_dispatcher.md
Name: sprite_cmd_dispatcher

Overview:
- Upstream feeder for every sprite display component; sits between the CPU Avalon-MM slave port and the shared 32-bit command bus.
- Buffers CPU command words in a FIFO and broadcasts one word per cycle on cmd_out.
- Holds buffer-swap commands (action field 4'hF) until the start of vertical blank, so ping/pong toggles never occur mid-frame.
- Drives a NOP word whenever it has nothing to issue.

Parameters:
- FIFO_DEPTH, 16, command FIFO entries; must be a power of two, at least 2.
- ADDR_W, 4, log2(FIFO_DEPTH).
- VBLANK_LINE, 10'd480, first vcount value of vertical blank.
- NOP_WORD, 32'h0000_0000, idle bus value; action field 4'h0 decodes as no-op in every display component.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- chipselect  in  1  Avalon slave select.
- write  in  1  Avalon write strobe.
- writedata  in  32  CPU command word: [31:26] component, [20:17] action, [16:14] type, [13] toggle, [12:0] data.
- hcount  in  10  current horizontal count.
- vcount  in  10  current vertical count.
- cmd_out  out  32  registered broadcast word to the sprite display writedata inputs.
- fifo_full  out  1  FIFO count equals FIFO_DEPTH.
- fifo_empty  out  1  FIFO count equals 0.
- overflow  out  1  sticky; set when a write is rejected.
- swap_pending  out  1  high while in WAIT_SYNC.
- active_buffer  out  1  toggle bit [13] of the last issued swap command.
- issued_count  out  16  statistics; see Optional Feature.
- drop_count  out  16  statistics; see Optional Feature.

Behaviour:
- Reset (reset low, asynchronous):
  - FIFO pointers and count cleared.
  - cmd_out = NOP_WORD; overflow = 0; active_buffer = 0; state = IDLE.
  - Counters = 0; fifo_empty = 1; fifo_full = 0.
  - Any FIFO contents are discarded.
  - Deassertion is used as-is; the surrounding system synchronises it.
- Accept:
  - A word is accepted when chipselect && write && !fifo_full at a rising edge.
  - fifo_full comes from the registered count before that edge. A write in the same cycle as a pop while full is therefore rejected.
  - A rejected write sets overflow. overflow clears only on reset.
- Swap detection: a FIFO head word is a swap when bits [20:17] == 4'hF.
- vblank_start is high when vcount == VBLANK_LINE && hcount == 0. It is a one-cycle qualifier.
- FSM:
  - IDLE: cmd_out <= NOP_WORD.
    - If FIFO not empty and head is not a swap: pop, cmd_out <= head, stay IDLE. Back-to-back issue gives one word per cycle.
    - If head is a swap: do not pop; go to WAIT_SYNC with cmd_out <= NOP_WORD.
  - WAIT_SYNC: cmd_out <= NOP_WORD; swap_pending = 1; FIFO accepts writes but nothing is popped.
    - On vblank_start: pop the swap, cmd_out <= swap word, active_buffer <= word[13], go to IDLE.
  - Words after a swap in the FIFO are never issued before that swap.
- Latency:
  - A write accepted at edge E0 into an empty FIFO, non-swap, in IDLE appears on cmd_out after edge E1 and holds for exactly one cycle.
  - cmd_out returns to NOP_WORD after E2 unless another word issues.
  - There is no write-to-output bypass.
- A swap at the head when vblank_start is already high at the cycle of first arrival issues immediately; the IDLE-to-WAIT_SYNC check and the vblank test evaluate in the same cycle.
- Pointers wrap modulo FIFO_DEPTH. The count is ADDR_W+1 bits wide.
- fifo_full and fifo_empty are combinational from the registered count.
- Reset asserted in WAIT_SYNC discards the pending swap. active_buffer returns to 0.

Optional Feature:
- Macro: DISPATCH_STATS_EN.
- Defined:
  - issued_count increments on every non-NOP issue.
  - drop_count increments on every rejected write.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: issued_count and drop_count are tied to 16'h0. No counter registers are built.

Test Plan:
- Reset: hold reset low with writes active, then release -> cmd_out = 32'h0, fifo_empty = 1, overflow = 0, active_buffer = 0.
- Single command: write 32'h2402_800A (component 9, action 1, type 2, X = 10) at edge E0 -> cmd_out = 32'h2402_800A after E1 only, 32'h0 after E2.
- Burst: write 3 words on consecutive cycles -> the same 3 words appear on cmd_out on 3 consecutive cycles, in order.
- Swap hold: write 32'h001E_2000 (action F, toggle 1) at vcount = 100, then a position word -> swap_pending = 1 and cmd_out stays 32'h0 until vcount = 480, hcount = 0. Then the swap issues, active_buffer = 1, and the position word issues the next cycle.
- Overflow: write 17 words while a swap is pending -> fifo_full = 1 after 16 writes, the 17th is dropped, overflow = 1, drop_count = 1 (with DISPATCH_STATS_EN).
- Reset mid-wait: assert reset while swap_pending = 1 -> swap_pending = 0, fifo_empty = 1, and nothing issues at the next vblank.
